// File: rtl/uart_rx_pkg.sv
// Shared types and register map constants for the UART receiver peripheral.
package uart_rx_pkg;

    // Receiver deframing states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Register offsets, selected by device_addr_i[3:2]
    localparam logic [1:0] REG_RX_DATA = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    // STATUS bit positions
    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERRUN   = 2;
    localparam int STATUS_FRAME_ERR = 3;

    // CTRL bit positions
    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    // RX_DATA flag raised when the read found the FIFO empty
    localparam int RX_DATA_EMPTY = 31;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with flush; rdata always shows the oldest entry.
module uart_rx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CntW'(Depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy tracking; flush wins over any same-cycle push/pop
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CntW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CntW'(1);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk_sys_i) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with RX FIFO, status flags and level IRQ.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int RxFifoDepth    = 8
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);
    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] MidCnt  = CntW'(ClksPerBit / 2 - 1);
    localparam int FifoCntW   = $clog2(RxFifoDepth) + 1;

    logic                rx_meta;
    logic                rx_s;
    rx_state_e           state;
    logic [CntW-1:0]     bit_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_reg;
    logic                rx_en;
    logic                irq_en;
    logic                overrun;
    logic                frame_err;
    logic                stop_done;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic [7:0]          fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    logic [1:0]          reg_sel;
    logic                rd_req;
    logic                wr_req;
    logic                status_wr;
    logic                ctrl_wr;
    logic                overrun_set;
    logic                frame_err_set;
    logic [31:0]         count_ext;
    logic [3:0]          count_sat;
    logic [31:0]         status_word;
    logic [31:0]         rdata_next;
    logic                unused_bus_bits;

    assign unused_bus_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                               device_be_i[3:1], device_wdata_i[31:4]};

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Deframing FSM: mid-bit start check, then full-bit spacing for data and stop
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (!rx_en) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_cnt == MidCnt) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == LastCnt) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == LastCnt) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_done     = rx_en && (state == STOP) && (bit_cnt == LastCnt);
    assign fifo_push     = stop_done && rx_s;
    assign frame_err_set = stop_done && !rx_s;

    assign reg_sel     = device_addr_i[3:2];
    assign rd_req      = device_req_i && !device_we_i;
    assign wr_req      = device_req_i && device_we_i && device_be_i[0];
    assign status_wr   = wr_req && (reg_sel == REG_STATUS);
    assign ctrl_wr     = wr_req && (reg_sel == REG_CTRL);
    assign fifo_pop    = rd_req && (reg_sel == REG_RX_DATA) && !fifo_empty;
    assign fifo_flush  = ctrl_wr && device_wdata_i[CTRL_FLUSH];
    assign overrun_set = fifo_push && fifo_full && !fifo_pop && !fifo_flush;

    uart_rx_fifo #(
        .Depth (RxFifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .wdata      (shift_reg),
        .rdata      (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Read mux: STATUS saturates the count at 15, empty RX_DATA reads return only the flag
    always_comb begin
        count_ext   = 32'(fifo_count);
        count_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
        status_word = {24'h0, count_sat, frame_err, overrun, fifo_full, fifo_empty};
        rdata_next  = '0;
        unique case (reg_sel)
            REG_RX_DATA: begin
                if (fifo_empty) rdata_next[RX_DATA_EMPTY] = 1'b1;
                else            rdata_next[7:0] = fifo_rdata;
            end
            REG_STATUS: rdata_next = status_word;
            REG_CTRL:   rdata_next = {30'h0, irq_en, rx_en};
            default:    rdata_next = '0;
        endcase
    end

    // Sticky error flags; a same-cycle set beats a write-1-to-clear
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set |
                         (overrun & ~(status_wr & device_wdata_i[STATUS_OVERRUN]));
            frame_err <= frame_err_set |
                         (frame_err & ~(status_wr & device_wdata_i[STATUS_FRAME_ERR]));
        end
    end

    // Control register; the flush bit is a strobe and is not stored
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_en  <= 1'b0;
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            rx_en  <= device_wdata_i[CTRL_RX_EN];
            irq_en <= device_wdata_i[CTRL_IRQ_EN];
        end
    end

    // Bus response one cycle after every request; writes return zero data
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            if (device_req_i) device_rdata_o <= rd_req ? rdata_next : 32'h0;
        end
    end

    // Level interrupt registered from the current flag and FIFO state
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) irq_o <= 1'b0;
        else             irq_o <= irq_en & (~fifo_empty | overrun | frame_err);
    end

endmodule
